// File: rtl/alu_pkg.sv
// Shared ALU constants: data/opcode widths and the opcode encoding.
package alu_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_CMP = 3'b010,
    OP_ROR = 3'b011,
    OP_ROL = 3'b100
  } op_e;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: adder, subtractor, comparator and rotators,
// muxed by opcode into a result plus flags.
module adder
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   sum
);
  assign sum = {1'b0, a} + {1'b0, b};
endmodule

module sub
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   diff
);
  // MSB of the 33-bit difference is the borrow (a < b unsigned).
  assign diff = {1'b0, a} - {1'b0, b};
endmodule

module cmp
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt,
  output logic              eq
);
  assign gt = (a > b);
  assign eq = (a == b);
endmodule

module right_rotate
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [4:0]        n,
  output logic [DATA_W-1:0] y
);
  // n=0 gives a shift by 32, which clears the second term and returns a.
  assign y = (a >> n) | (a << (6'd32 - {1'b0, n}));
endmodule

module left_rotate
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [4:0]        n,
  output logic [DATA_W-1:0] y
);
  assign y = (a << n) | (a >> (6'd32 - {1'b0, n}));
endmodule

module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              zero,
  output logic              gt,
  output logic              err
);
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              cmp_gt;
  logic              cmp_eq;
  logic [DATA_W-1:0] ror_y;
  logic [DATA_W-1:0] rol_y;

  adder        u_add (.a(a), .b(b), .sum(sum));
  sub          u_sub (.a(a), .b(b), .diff(diff));
  cmp          u_cmp (.a(a), .b(b), .gt(cmp_gt), .eq(cmp_eq));
  right_rotate u_ror (.a(a), .n(b[4:0]), .y(ror_y));
  left_rotate  u_rol (.a(a), .n(b[4:0]), .y(rol_y));

  always_comb begin
    result = '0;
    cout   = 1'b0;
    zero   = 1'b0;
    gt     = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
        zero   = (sum[DATA_W-1:0] == '0);
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        cout   = diff[DATA_W];
        zero   = (diff[DATA_W-1:0] == '0);
      end
      OP_CMP: begin
        result = {{(DATA_W-1){1'b0}}, cmp_gt};
        zero   = cmp_eq;
        gt     = cmp_gt;
      end
      OP_ROR: begin
        result = ror_y;
        zero   = (ror_y == '0);
      end
      OP_ROL: begin
        result = rol_y;
        zero   = (rol_y == '0);
      end
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute pipeline (operand capture, then result/flags) with
// valid/ready handshakes on both sides and a completed-transfer counter.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              flag_cout,
  output logic              flag_zero,
  output logic              flag_gt,
  output logic              flag_err,
  output logic [CNT_W-1:0]  op_count
);
  logic              s1_valid;
  logic [OP_W-1:0]   s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_result;
  logic              s2_cout;
  logic              s2_zero;
  logic              s2_gt;
  logic              s2_err;

  logic [DATA_W-1:0] c_result;
  logic              c_cout;
  logic              c_zero;
  logic              c_gt;
  logic              c_err;

  logic in_xfer;
  logic out_xfer;
  logic s2_load;

  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = rst_n && (!s1_valid || s2_load);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = s2_valid && out_ready;

  alu_core u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (c_result),
    .cout   (c_cout),
    .zero   (c_zero),
    .gt     (c_gt),
    .err    (c_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_op    <= op;
      s1_a     <= a;
      s1_b     <= b;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // A load takes priority over the drain, so a transfer and refill in the
  // same edge leaves no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_cout   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_gt     <= 1'b0;
      s2_err    <= 1'b0;
    end else if (s2_load) begin
      s2_valid  <= 1'b1;
      s2_result <= c_result;
      s2_cout   <= c_cout;
      s2_zero   <= c_zero;
      s2_gt     <= c_gt;
      s2_err    <= c_err;
    end else if (out_xfer) begin
      s2_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_xfer) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign flag_cout = s2_cout;
  assign flag_zero = s2_zero;
  assign flag_gt   = s2_gt;
  assign flag_err  = s2_err;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (narrow counter to reach wrap).
module tb_alu_exec_stage;
  localparam int unsigned TB_CNT_W = 4;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          op;
  logic [31:0]         a;
  logic [31:0]         b;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         result;
  logic                flag_cout;
  logic                flag_zero;
  logic                flag_gt;
  logic                flag_err;
  logic [TB_CNT_W-1:0] op_count;

  int unsigned         checks;
  int unsigned         errors;
  logic [TB_CNT_W-1:0] exp_cnt;

  alu_exec_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_cout (flag_cout),
    .flag_zero (flag_zero),
    .flag_gt   (flag_gt),
    .flag_err  (flag_err),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #3;
    checks++;
    if ({out_valid, in_ready, flag_cout, flag_zero, flag_gt, flag_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {out_valid, in_ready, flag_cout, flag_zero, flag_gt, flag_err});
    end
    checks++;
    if (result !== 32'h0 || op_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: result=%h op_count=%0d expected 0/0", result, op_count);
    end
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    exp_cnt = '0;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h1);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_latency: out_valid=%b expected 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h0 ||
        {flag_cout, flag_zero, flag_gt, flag_err} !== 4'b1100) begin
      errors++;
      $display("FAIL add_wrap: v=%b result=%h flags=%b expected 1/00000000/1100",
               out_valid, result, {flag_cout, flag_zero, flag_gt, flag_err});
    end
    step();
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (out_valid !== 1'b0 || op_count !== exp_cnt) begin
      errors++;
      $display("FAIL add_count: v=%b op_count=%0d expected 0/%0d", out_valid, op_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 3'b001, 32'd5, 32'd7);
    step();
    drive(1'b1, 3'b010, 32'd9, 32'd3);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE ||
        {flag_cout, flag_zero, flag_gt, flag_err} !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_sub: v=%b result=%h flags=%b expected 1/fffffffe/1000",
               out_valid, result, {flag_cout, flag_zero, flag_gt, flag_err});
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h1 ||
        {flag_cout, flag_zero, flag_gt, flag_err} !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_cmp: v=%b result=%h flags=%b expected 1/00000001/0010",
               out_valid, result, {flag_cout, flag_zero, flag_gt, flag_err});
    end
    step();
    exp_cnt = exp_cnt + 2'd2;
    checks++;
    if (op_count !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_count: op_count=%0d expected %0d", op_count, exp_cnt);
    end
  endtask

  task automatic test_rotate();
    logic [2:0]  t_op  [6];
    logic [31:0] t_a   [6];
    logic [31:0] t_b   [6];
    logic [31:0] t_exp [6];
    t_op[0] = 3'b011; t_a[0] = 32'h8000_0001; t_b[0] = 32'd1;  t_exp[0] = 32'hC000_0000;
    t_op[1] = 3'b100; t_a[1] = 32'h1234_5678; t_b[1] = 32'd0;  t_exp[1] = 32'h1234_5678;
    t_op[2] = 3'b100; t_a[2] = 32'h0000_0001; t_b[2] = 32'd32; t_exp[2] = 32'h0000_0001;
    t_op[3] = 3'b100; t_a[3] = 32'h8000_0001; t_b[3] = 32'd1;  t_exp[3] = 32'h0000_0003;
    t_op[4] = 3'b011; t_a[4] = 32'h0000_00F1; t_b[4] = 32'd4;  t_exp[4] = 32'h1000_000F;
    t_op[5] = 3'b011; t_a[5] = 32'h0000_0000; t_b[5] = 32'd7;  t_exp[5] = 32'h0000_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, t_op[i], t_a[i], t_b[i]);
      step();
      drive(1'b0, 3'b000, 32'h0, 32'h0);
      step();
      checks++;
      if (out_valid !== 1'b1 || result !== t_exp[i] ||
          {flag_cout, flag_zero, flag_gt, flag_err} !== {1'b0, t_exp[i] == 32'h0, 2'b00}) begin
        errors++;
        $display("FAIL rotate_%0d: v=%b result=%h flags=%b expected 1/%h/%b", i, out_valid,
                 result, {flag_cout, flag_zero, flag_gt, flag_err}, t_exp[i],
                 {1'b0, t_exp[i] == 32'h0, 2'b00});
      end
    end
    step();
    exp_cnt = exp_cnt + 3'd6;
    checks++;
    if (op_count !== exp_cnt) begin
      errors++;
      $display("FAIL rotate_count: op_count=%0d expected %0d", op_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [TB_CNT_W-1:0] base;
    base = exp_cnt;
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'd1, 32'd2);
    step();
    drive(1'b1, 3'b001, 32'd10, 32'd4);
    step();
    drive(1'b1, 3'b000, 32'd100, 32'd200);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd3 ||
          {flag_cout, flag_zero, flag_gt, flag_err} !== 4'b0000) begin
        errors++;
        $display("FAIL stall_hold_%0d: in_ready=%b v=%b result=%h flags=%b expected 0/1/00000003/0000",
                 i, in_ready, out_valid, result, {flag_cout, flag_zero, flag_gt, flag_err});
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: in_ready=%b expected 1", in_ready);
    end
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd6 || op_count !== base + 1'b1) begin
      errors++;
      $display("FAIL stall_second: v=%b result=%h op_count=%0d expected 1/00000006/%0d",
               out_valid, result, op_count, base + 1'b1);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h12C || op_count !== base + 2'd2) begin
      errors++;
      $display("FAIL stall_third: v=%b result=%h op_count=%0d expected 1/0000012c/%0d",
               out_valid, result, op_count, base + 2'd2);
    end
    step();
    exp_cnt = base + 2'd3;
    checks++;
    if (out_valid !== 1'b0 || op_count !== exp_cnt) begin
      errors++;
      $display("FAIL stall_drain: v=%b op_count=%0d expected 0/%0d", out_valid, op_count, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(1'b1, 3'b110, 32'd5, 32'd5);
    step();
    drive(1'b1, 3'b111, 32'd0, 32'd0);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h0 ||
        {flag_cout, flag_zero, flag_gt, flag_err} !== 4'b0001) begin
      errors++;
      $display("FAIL illegal_110: v=%b result=%h flags=%b expected 1/00000000/0001",
               out_valid, result, {flag_cout, flag_zero, flag_gt, flag_err});
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h0 ||
        {flag_cout, flag_zero, flag_gt, flag_err} !== 4'b0001) begin
      errors++;
      $display("FAIL illegal_111: v=%b result=%h flags=%b expected 1/00000000/0001",
               out_valid, result, {flag_cout, flag_zero, flag_gt, flag_err});
    end
    step();
    exp_cnt = exp_cnt + 2'd2;
    checks++;
    if (op_count !== exp_cnt) begin
      errors++;
      $display("FAIL illegal_count: op_count=%0d expected %0d", op_count, exp_cnt);
    end
  endtask

  task automatic test_stream_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(1'b1, 3'b000, i, i);
      else        drive(1'b0, 3'b000, 32'h0, 32'h0);
      step();
      if (i >= 1 && i <= 16) begin
        checks++;
        if (out_valid !== 1'b1 || result !== 32'(2 * (i - 1))) begin
          errors++;
          $display("FAIL stream_%0d: v=%b result=%h expected 1/%h", i, out_valid, result,
                   32'(2 * (i - 1)));
        end
      end
    end
    checks++;
    if (op_count !== exp_cnt || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_wrap: op_count=%0d v=%b expected %0d/0", op_count, out_valid, exp_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'd7, 32'd8);
    step();
    drive(1'b1, 3'b000, 32'd9, 32'd9);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || op_count == 4'd0) begin
      errors++;
      $display("FAIL midreset_pre: v=%b in_ready=%b op_count=%0d expected 1/0/nonzero",
               out_valid, in_ready, op_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || op_count !== 4'd0 || result !== 32'h0) begin
      errors++;
      $display("FAIL midreset_now: v=%b in_ready=%b op_count=%0d result=%h expected 0/0/0/0",
               out_valid, in_ready, op_count, result);
    end
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: in_ready=%b expected 1", in_ready);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (out_valid !== 1'b0 || op_count !== 4'd0) begin
      errors++;
      $display("FAIL midreset_discard: v=%b op_count=%0d expected 0/0", out_valid, op_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_rotate();
    test_backpressure();
    test_illegal();
    test_stream_wrap();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter: CNT_W, 16, width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request present on op/a/b.
REQ-005 in_ready  output  1  stage can accept a request this cycle.
REQ-006 op  input  3  opcode: 000 add, 001 sub, 010 cmp, 011 ror, 100 rol, 101-111 illegal.
REQ-007 a  input  32  operand A.
REQ-008 b  input  32  operand B; rotates use b[4:0] only.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 result  output  32  operation result.
REQ-012 flag_cout  output  1  carry (add) or borrow (sub); 0 for all other ops.
REQ-013 flag_zero  output  1  add/sub: result==0; cmp: a==b; rotates: result==0; illegal: 0.
REQ-014 flag_gt  output  1  cmp: unsigned a>b; 0 for all other ops.
REQ-015 flag_err  output  1  illegal opcode.
REQ-016 op_count  output  CNT_W  number of completed output transfers, modulo 2^CNT_W.

Function
REQ-017 Two register stages: S1 (operand/op capture), S2 (computed result and flags); each has its own valid bit.
REQ-018 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-019 Advance rule: S2 loads when S1 is valid and (S2 is empty or out_ready=1); S1 loads when an input transfer occurs.
REQ-020 in_ready = rst_n && (S1 empty || S1 advances this cycle); it is combinational, with no dependency on in_valid.
REQ-021 Latency: a request accepted at edge N appears with out_valid=1 after edge N+1; sustained throughput is 1 op/cycle when out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, result and all flags are held stable, and S1 holds at most one further request.
REQ-023 Arithmetic: add {cout,result}=a+b (33-bit); sub {cout,result}=a-b (33-bit, cout=1 iff a<b unsigned); cmp result={31'b0,a>b}.
REQ-024 Rotates: ror result=(a>>n)|(a<<(32-n)) and rol result=(a<<n)|(a>>(32-n)), with n=b[4:0]; n=0 returns a unchanged.
REQ-025 Illegal opcode: result=0, flag_err=1, and all other flags 0; the request still completes a normal transfer.
REQ-026 op_count increments by 1 on each output transfer and wraps from all-ones to 0.
REQ-027 Simultaneous output transfer and S1 advance: S2 loads the new S1 contents in the same edge, with no bubble.

Reset
REQ-028 While rst_n=0: S1/S2 valid bits=0, out_valid=0, in_ready=0, result=0, all flags=0, op_count=0.
REQ-029 Reset asserted mid-operation discards both in-flight requests, and no output transfer occurs for them.
REQ-030 in_ready goes to 1 in the first cycle with rst_n=1.

Structure
REQ-031 Shared package alu_pkg holds the opcode constants (OP_ADD..OP_ROL), the opcode width, and the data width 32.
REQ-032 Combinational compute is one sub-module, alu_core, which instances adder, sub, cmp, right_rotate and left_rotate and muxes by op.
REQ-033 alu_exec_stage contains only the handshake, the S1/S2 registers and op_count.

Verification
REQ-034 Add a=FFFFFFFF, b=1 -> two cycles later result=0, cout=1, zero=1.
REQ-035 Back-to-back sub 5-7 then cmp 9,3 with out_ready=1 -> sub result=FFFFFFFE with cout=1, then cmp result=1 with gt=1 in the next cycle.
REQ-036 ror a=80000001, b=1 -> result=C0000000; rol with b=0 -> result=a; rol a=1, b=32 (b[4:0]=0) -> result=1.
REQ-037 out_ready=0 for 5 cycles with 3 requests offered -> 2 accepted, in_ready=0, result stable; release -> results in order, op_count=2 after both transfers, third request then accepted.
REQ-038 op=110 -> result=0, err=1; reset asserted with S1 and S2 full -> out_valid=0 immediately and op_count=0.
